cam_pixel_receive: RTL

Parametrised camera pixel receiver for OV-series sensors (DVP: D bus, VSYNC, HREF, PCLK). Assembles BYTES_PER_PIXEL sensor bytes into one pixel word (RGB565, RGB888, YUV, raw). Adds pixel/line coordinates, frame/line markers, a frame-granular enable, configurable frame skipping and line-length error detection. Sits directly behind the camera pins in the PCLK domain, feeding downstream vision/FIFO logic.

---
 rtl/cam_pixel_receive.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cam_pixel_receive.sv
// -----------------------------------------------------------------------------
// cam_pixel_receive
//
// DVP camera pixel receiver for OV-series sensors. It lives in the PCLK domain
// directly behind the sensor pins. It packs BYTES_PER_PIXEL bus beats into one
// pixel word, with the first beat in the MSBs. Each presented pixel carries
// column/line coordinates and frame/line markers. Capture starts and stops on
// whole-frame boundaries only. The first SKIP_FRAMES frames after reset are
// discarded, and lines whose byte count is not a multiple of BYTES_PER_PIXEL
// are flagged.
//
// Ports
//   pclk_i        pixel clock, all logic on the rising edge
//   rst_i         synchronous reset, active-low
//   d_i           sensor data bus
//   vsync_i       high = vertical blanking
//   href_i        high = valid line data
//   en_i          capture enable, sampled only at frame start (vsync fall)
//   pixelReady_o  one-cycle strobe: pixel_o / x_o / y_o valid
//   pixel_o       assembled pixel word
//   x_o, y_o      column / line of the presented pixel
//   frameStart_o  strobe with the first pixel of a captured frame
//   frameEnd_o    strobe at the end of a captured frame
//   lineEnd_o     strobe at the end of each captured line
//   lineLen_o     pixel count of the line just ended (valid with lineEnd_o)
//   lineErr_o     strobe: line ended with a partial pixel
//   frameCount_o  captured frames completed, wraps 255 -> 0
//
// Handshake: every output strobe is a valid-only pulse with no ready.
// Downstream logic must accept each pulse in the cycle it is high. The
// sensor cannot be stalled, so there is no backpressure path.
// -----------------------------------------------------------------------------
module cam_pixel_receive #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int X_W             = 11,
  parameter int Y_W             = 10,
  parameter int SKIP_FRAMES     = 1
) (
  input  logic                              pclk_i,
  input  logic                              rst_i,
  input  logic [DATA_W-1:0]                 d_i,
  input  logic                              vsync_i,
  input  logic                              href_i,
  input  logic                              en_i,
  output logic                              pixelReady_o,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0] pixel_o,
  output logic [X_W-1:0]                    x_o,
  output logic [Y_W-1:0]                    y_o,
  output logic                              frameStart_o,
  output logic                              frameEnd_o,
  output logic                              lineEnd_o,
  output logic [X_W-1:0]                    lineLen_o,
  output logic                              lineErr_o,
  output logic [7:0]                        frameCount_o
);

  localparam int PIX_W  = DATA_W * BYTES_PER_PIXEL;
  localparam int CNT_W  = 2;  // byte counter covers 1..4 beats per pixel
  localparam int SKIP_W = 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,  // wait for a clean frame boundary
    S_VBLANK = 2'd1,  // blanking, decide at vsync fall whether to capture
    S_SKIP   = 2'd2,  // frame being discarded
    S_ACTIVE = 2'd3   // frame being captured
  } state_e;

  state_e              state_q, state_d;
  logic                href_dly_q, vsync_dly_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [PIX_W-1:0]    asm_q, asm_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                armed_q, armed_d;

  logic                rdy_q, rdy_d;
  logic [PIX_W-1:0]    pixel_q, pixel_d;
  logic [X_W-1:0]      xo_q, xo_d;
  logic [Y_W-1:0]      yo_q, yo_d;
  logic                fstart_q, fstart_d;
  logic                fend_q, fend_d;
  logic                lend_q, lend_d;
  logic [X_W-1:0]      llen_q, llen_d;
  logic                lerr_q, lerr_d;
  logic [7:0]          fcount_q, fcount_d;

  logic                vs_rise, vs_fall, href_fall;
  logic                capture, line_end;
  logic [PIX_W-1:0]    pix_word;

  assign vs_rise   = vsync_i & ~vsync_dly_q;
  assign vs_fall   = ~vsync_i & vsync_dly_q;
  assign href_fall = ~href_i & href_dly_q;

  // Capture and line end never coincide. A capture needs href high and vsync
  // low, while a line end needs href falling or vsync rising.
  assign capture  = (state_q == S_ACTIVE) & ~vsync_i & href_i;
  assign line_end = (state_q == S_ACTIVE) & (href_fall | (vs_rise & href_dly_q));

  // Shift the new beat into the LSBs. Once BYTES_PER_PIXEL beats have been
  // taken, the first beat sits in the MSBs.
  assign pix_word = (asm_q << DATA_W) | PIX_W'(d_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    asm_d    = asm_q;
    x_d      = x_q;
    y_d      = y_q;
    armed_d  = armed_q;
    rdy_d    = 1'b0;
    pixel_d  = pixel_q;
    xo_d     = xo_q;
    yo_d     = yo_q;
    fstart_d = 1'b0;
    fend_d   = 1'b0;
    lend_d   = 1'b0;
    llen_d   = llen_q;
    lerr_d   = 1'b0;
    fcount_d = fcount_q;

    unique case (state_q)
      S_SYNC: begin
        if (vsync_i) state_d = S_VBLANK;
      end

      S_VBLANK: begin
        if (vs_fall) begin
          if (!en_i) begin
            state_d = S_SKIP;
          end else if (skip_q != '0) begin
            skip_d  = skip_q - 1'b1;
            state_d = S_SKIP;
          end else begin
            state_d = S_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            armed_d = 1'b1;
          end
        end
      end

      S_SKIP: begin
        if (vs_rise) state_d = S_VBLANK;
      end

      S_ACTIVE: begin
        if (capture) begin
          asm_d = pix_word;
          if (cnt_q == LAST_BEAT) begin
            pixel_d = pix_word;
            rdy_d   = 1'b1;
            xo_d    = x_q;
            yo_d    = y_q;
            cnt_d   = '0;
            x_d     = (x_q == '1) ? x_q : x_q + 1'b1;
            if (armed_q) begin
              fstart_d = 1'b1;
              armed_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        if (line_end) begin
          lend_d = 1'b1;
          llen_d = x_q;
          lerr_d = (cnt_q != '0);
          cnt_d  = '0;
          x_d    = '0;
          y_d    = (y_q == '1) ? y_q : y_q + 1'b1;
        end

        if (vs_rise) begin
          state_d  = S_VBLANK;
          fend_d   = 1'b1;
          fcount_d = fcount_q + 8'd1;
        end
      end

      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!rst_i) begin
      state_q     <= S_SYNC;
      href_dly_q  <= 1'b0;
      vsync_dly_q <= 1'b0;
      cnt_q       <= '0;
      skip_q      <= SKIP_W'(SKIP_FRAMES);
      asm_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      armed_q     <= 1'b0;
      rdy_q       <= 1'b0;
      pixel_q     <= '0;
      xo_q        <= '0;
      yo_q        <= '0;
      fstart_q    <= 1'b0;
      fend_q      <= 1'b0;
      lend_q      <= 1'b0;
      llen_q      <= '0;
      lerr_q      <= 1'b0;
      fcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      href_dly_q  <= href_i;
      vsync_dly_q <= vsync_i;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      asm_q       <= asm_d;
      x_q         <= x_d;
      y_q         <= y_d;
      armed_q     <= armed_d;
      rdy_q       <= rdy_d;
      pixel_q     <= pixel_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
      fstart_q    <= fstart_d;
      fend_q      <= fend_d;
      lend_q      <= lend_d;
      llen_q      <= llen_d;
      lerr_q      <= lerr_d;
      fcount_q    <= fcount_d;
    end
  end

  assign pixelReady_o = rdy_q;
  assign pixel_o      = pixel_q;
  assign x_o          = xo_q;
  assign y_o          = yo_q;
  assign frameStart_o = fstart_q;
  assign frameEnd_o   = fend_q;
  assign lineEnd_o    = lend_q;
  assign lineLen_o    = llen_q;
  assign lineErr_o    = lerr_q;
  assign frameCount_o = fcount_q;

endmodule
